// File: rtl/sensor_conditioner_pkg.sv
// Shared constants for the lot-gate sensor conditioner: channel indices and parameter defaults.
// STUCK_CYCLES_DEF is only consumed when STUCK_DETECT_EN is defined.
package sensor_conditioner_pkg;

   localparam int CH1 = 0;
   localparam int CH2 = 1;

   localparam int SYNC_STAGES_DEF     = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 4;
   localparam int STUCK_CYCLES_DEF    = 1024;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Sensor-side bundle: raw gate inputs in, clean levels and edge/fault flags out.
// slave = conditioner side, master = whoever drives the raw gate lines.
interface sensor_conditioner_if;
   logic       raw1;
   logic       raw2;
   logic       sens1;
   logic       sens2;
   logic [1:0] rise;
   logic [1:0] fall;
   logic [1:0] fault;

   modport master (output raw1, raw2, input sens1, sens2, rise, fall, fault);
   modport slave  (input raw1, raw2, output sens1, sens2, rise, fall, fault);
endinterface

// File: rtl/sensor_debounce_ch.sv
// One sensor channel: synchroniser, debounce counter, registered edge pulses.
// Optional stuck-high detector built only when STUCK_DETECT_EN is defined.
module sensor_debounce_ch
   import sensor_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef STUCK_DETECT_EN
   ,
   parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic sens,
   output logic rise,
   output logic fall,
   output logic fault
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_x;
   logic                   clean;
   logic                   clean_next;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_next;
   logic                   fault_next;
   logic                   sens_next;

   assign sync_x = sync_q[SYNC_STAGES-1];

   // Count consecutive disagreeing samples; accept on the last one and restart.
   always_comb begin
      clean_next = clean;
      cnt_next   = '0;
      if (sync_x != clean) begin
         if (cnt == DEB_LAST) begin
            clean_next = sync_x;
         end else begin
            cnt_next = cnt + 1'b1;
         end
      end
   end

`ifdef STUCK_DETECT_EN
   localparam int SW = $clog2(STUCK_CYCLES + 1);
   localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);
   localparam logic [SW-1:0] STUCK_MAX  = SW'(STUCK_CYCLES);

   logic [SW-1:0] stuck_cnt;
   logic [SW-1:0] stuck_next;
   logic          fault_q;

   always_comb begin
      stuck_next = '0;
      fault_next = fault_q;
      if (clean) begin
         if (stuck_cnt == STUCK_LAST) fault_next = 1'b1;
         stuck_next = (stuck_cnt == STUCK_MAX) ? stuck_cnt : stuck_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stuck_cnt <= '0;
         fault_q   <= 1'b0;
      end else begin
         stuck_cnt <= stuck_next;
         fault_q   <= fault_next;
      end
   end

   assign fault = fault_q;
`else
   assign fault_next = 1'b0;
   assign fault      = 1'b0;
`endif

   // A fault masks the level, so the forcing cycle shows up as an ordinary fall.
   assign sens_next = clean_next & ~fault_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         clean  <= 1'b0;
         cnt    <= '0;
         sens   <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         clean  <= clean_next;
         cnt    <= cnt_next;
         sens   <= sens_next;
         rise   <= sens_next & ~sens;
         fall   <= ~sens_next & sens;
      end
   end

endmodule

// File: rtl/sensor_conditioner.sv
// Two-channel lot-gate input conditioner feeding the counter FSM's sens1/sens2.
// Define STUCK_DETECT_EN to build the per-channel stuck-high fault detectors.
module sensor_conditioner
   import sensor_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef STUCK_DETECT_EN
   ,
   parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
`endif
) (
   input  logic               clk,
   input  logic               rst,
   sensor_conditioner_if.slave bus
);

   logic [1:0] raw_v;
   logic [1:0] sens_v;
   logic [1:0] rise_v;
   logic [1:0] fall_v;
   logic [1:0] fault_v;

   assign raw_v[CH1] = bus.raw1;
   assign raw_v[CH2] = bus.raw2;

   // Channels are fully independent; simultaneous qualifications update together.
   for (genvar i = 0; i < 2; i++) begin : g_ch
      sensor_debounce_ch #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef STUCK_DETECT_EN
         ,
         .STUCK_CYCLES    (STUCK_CYCLES)
`endif
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .raw   (raw_v[i]),
         .sens  (sens_v[i]),
         .rise  (rise_v[i]),
         .fall  (fall_v[i]),
         .fault (fault_v[i])
      );
   end

   assign bus.sens1 = sens_v[CH1];
   assign bus.sens2 = sens_v[CH2];
   assign bus.rise  = rise_v;
   assign bus.fall  = fall_v;
   assign bus.fault = fault_v;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed scenarios plus random raw activity against a
// sample-window reference model. Stuck-high scenario is built when STUCK_DETECT_EN is defined.
module tb_sensor_conditioner;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int STK  = 16;
   localparam int HL   = SYNC + DEB;

   logic clk = 1'b0;
   logic rst = 1'b0;

   sensor_conditioner_if bus ();

   sensor_conditioner #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB)
`ifdef STUCK_DETECT_EN
      ,
      .STUCK_CYCLES    (STK)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference: raw sample history per channel; the level flips once the DEB samples that
   // reached the end of the synchroniser all disagree with the current clean level.
   bit hist [2][HL];
   bit m_clean [2];
   bit m_sens [2];
   bit m_rise [2];
   bit m_fall [2];
   bit m_fault [2];
   int m_run [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < HL; i++) hist[c][i] = 1'b0;
         m_clean[c] = 1'b0;
         m_sens[c]  = 1'b0;
         m_rise[c]  = 1'b0;
         m_fall[c]  = 1'b0;
         m_fault[c] = 1'b0;
         m_run[c]   = 0;
      end
   endtask

   task automatic model_edge(input bit r1, input bit r2);
      bit r [2];
      bit all_diff;
      bit new_clean;
      bit new_sens;
      r[0] = r1;
      r[1] = r2;
      for (int c = 0; c < 2; c++) begin
         for (int i = HL - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
         hist[c][0] = r[c];
         all_diff = 1'b1;
         for (int i = SYNC; i < HL; i++) if (hist[c][i] == m_clean[c]) all_diff = 1'b0;
         new_clean = all_diff ? ~m_clean[c] : m_clean[c];
`ifdef STUCK_DETECT_EN
         if (m_clean[c]) m_run[c]++;
         else m_run[c] = 0;
         if (m_run[c] >= STK) m_fault[c] = 1'b1;
`endif
         new_sens   = new_clean & ~m_fault[c];
         m_rise[c]  = new_sens & ~m_sens[c];
         m_fall[c]  = ~new_sens & m_sens[c];
         m_sens[c]  = new_sens;
         m_clean[c] = new_clean;
      end
   endtask

   task automatic check_outputs();
      check("sens1", 32'(bus.sens1), 32'(m_sens[0]));
      check("sens2", 32'(bus.sens2), 32'(m_sens[1]));
      check("rise",  32'(bus.rise),  32'({m_rise[1], m_rise[0]}));
      check("fall",  32'(bus.fall),  32'({m_fall[1], m_fall[0]}));
      check("fault", 32'(bus.fault), 32'({m_fault[1], m_fault[0]}));
   endtask

   task automatic step(input bit r1, input bit r2);
      bus.raw1 = r1;
      bus.raw2 = r2;
      @(posedge clk);
      model_edge(r1, r2);
      #1;
      check_outputs();
   endtask

   // Reset is asserted between edges so the clear must be asynchronous.
   task automatic do_reset(input int cycles);
      rst = 1'b0;
      #1;
      model_reset();
      check("rst_sens", 32'({bus.sens2, bus.sens1}), 32'd0);
      check("rst_pulses", 32'({bus.rise, bus.fall, bus.fault}), 32'd0);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         check("rst_hold", 32'({bus.sens2, bus.sens1, bus.rise, bus.fall, bus.fault}), 32'd0);
      end
      rst = 1'b1;
   endtask

   // Steps with constant raw levels until the selected output goes high; -1 if the bound expires.
   task automatic measure(input bit r1, input bit r2, input int sel, output int n);
      bit hit;
      hit = 1'b0;
      n = -1;
      for (int i = 1; i <= 60 && !hit; i++) begin
         step(r1, r2);
         if ((sel == 0 && bus.sens1) || (sel == 1 && bus.sens2) || (sel == 2 && bus.fault[1])) begin
            hit = 1'b1;
            n = i;
         end
      end
   endtask

   initial begin
      int n;
      bit r1;
      bit r2;
      bus.raw1 = 1'b1;
      bus.raw2 = 1'b1;
      model_reset();
      #2;
      do_reset(4);

      // Single channel step: latency and lone rise pulse on channel 1.
      repeat (3) step(1'b0, 1'b0);
      measure(1'b1, 1'b0, 0, n);
      check("lat_ch1", 32'(n), 32'(SYNC + DEB));
      check("rise_ch1", 32'(bus.rise), 32'b01);
      check("sens2_idle", 32'(bus.sens2), 32'd0);
      step(1'b1, 1'b0);
      check("rise_1cyc", 32'(bus.rise), 32'b00);

      // Falls back and a 3-cycle glitch that must be rejected.
      repeat (10) step(1'b0, 1'b0);
      repeat (DEB - 1) step(1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b0);
      check("glitch_sens1", 32'(bus.sens1), 32'd0);

      // Both channels rising on the same edge.
      measure(1'b1, 1'b1, 0, n);
      check("lat_both", 32'(n), 32'(SYNC + DEB));
      check("rise_both", 32'(bus.rise), 32'b11);
      check("sens2_both", 32'(bus.sens2), 32'd1);
      repeat (10) step(1'b0, 1'b0);

      // Reset part-way through channel 2's count discards the partial count.
      repeat (SYNC + 2) step(1'b0, 1'b1);
      do_reset(2);
      measure(1'b0, 1'b1, 1, n);
      check("lat_after_rst", 32'(n), 32'(SYNC + DEB));
      repeat (10) step(1'b0, 1'b0);

`ifdef STUCK_DETECT_EN
      do_reset(1);
      measure(1'b0, 1'b1, 1, n);
      check("stuck_rise_lat", 32'(n), 32'(SYNC + DEB));
      measure(1'b0, 1'b1, 2, n);
      check("stuck_lat", 32'(n), 32'(STK));
      check("stuck_fall", 32'(bus.fall), 32'b10);
      check("stuck_sens2", 32'(bus.sens2), 32'd0);
      for (int i = 0; i < 120; i++) begin
         step(1'b0, (i / 7) % 2 == 0);
         check("stuck_norise", 32'(bus.rise[1]), 32'd0);
      end
      do_reset(1);
      check("stuck_clear", 32'(bus.fault), 32'd0);
`endif

      // Random activity: mixed short glitches and long holds, with occasional resets.
      r1 = 1'b0;
      r2 = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) r1 = ~r1;
         if ($urandom_range(7) == 0) r2 = ~r2;
         if ((i / 500) % 2 == 1 && $urandom_range(2) == 0) begin
            r1 = ~r1;
            r2 = ~r2;
         end
         if ($urandom_range(299) == 0) do_reset($urandom_range(3));
         else step(r1, r2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
